// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg: shared definitions for the USB full-speed receive path.
//   - PID codes (4-bit PID field, check nibble excluded)
//   - PID type field values (PID bits [1:0])
//   - CRC5 / CRC16 polynomials, initial values and good-packet residuals
//   - receive parser state enum and PID check helper
package usb_fs_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [1:0] PTYPE_SPECIAL   = 2'b00;
    localparam logic [1:0] PTYPE_TOKEN     = 2'b01;
    localparam logic [1:0] PTYPE_HANDSHAKE = 2'b10;
    localparam logic [1:0] PTYPE_DATA      = 2'b11;

    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PID  = 2'd1,
        ST_BODY = 2'd2
    } rx_state_e;

    // Upper nibble of the PID byte must be the ones-complement of the lower.
    function automatic logic pid_check_ok(input logic [7:0] pid_byte);
        return pid_byte[7:4] == ~pid_byte[3:0];
    endfunction

endpackage

// File: rtl/usb_fs_crc.sv
// usb_fs_crc: serial CRC register, one bit per cycle when bit_valid_i.
// Update: crc = {crc[W-2:0],0} ^ ((crc[W-1]^bit) ? POLY : 0).
// Ports:
//   clk          clock
//   clear_i      reload INIT (takes priority over bit_valid_i)
//   bit_valid_i  bit_i is a new serial bit
//   bit_i        serial data bit
//   crc_o        current CRC register contents
module usb_fs_crc #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = '0,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] crc_o
);

    logic [WIDTH-1:0] crc_q;
    logic [WIDTH-1:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = INIT;
        end else if (bit_valid_i) begin
            crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ ((crc_q[WIDTH-1] ^ bit_i) ? POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/usb_fs_rx_pkt.sv
// usb_fs_rx_pkt: USB full-speed packet parser. Turns the unstuffed bit
// stream into packet start/end/valid strobes, PID, token fields, SOF frame
// number and CRC-stripped data bytes. All packet checks live here.
//
// state | meaning
// IDLE  | waiting for SYNC (in_pkt_start)
// PID   | collecting the 8 PID bits
// BODY  | collecting token/data body bits, CRC running
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_pkt_start/in_pkt_end    SYNC / EOP strobes from the line decoder
//   in_bit_valid, in_bit       unstuffed payload bit, LSB first
//   in_error                   stuff/line error, poisons the current packet
//   rx_pkt_start/rx_pkt_end    packet strobes (one cycle after the inputs)
//   rx_pkt_valid               qualifies rx_pkt_end
//   rx_pid, rx_addr, rx_endp   last PID and token fields (held)
//   rx_frame_num               last SOF frame number (held)
//   rx_data_put, rx_data       payload byte strobe and byte
module usb_fs_rx_pkt
    import usb_fs_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_pkt_start,
    input  logic        in_bit_valid,
    input  logic        in_bit,
    input  logic        in_pkt_end,
    input  logic        in_error,
    output logic        rx_pkt_start,
    output logic        rx_pkt_end,
    output logic        rx_pkt_valid,
    output logic [3:0]  rx_pid,
    output logic [6:0]  rx_addr,
    output logic [3:0]  rx_endp,
    output logic [10:0] rx_frame_num,
    output logic        rx_data_put,
    output logic [7:0]  rx_data
);

    // Total bytes (PID + payload + CRC16) a data packet may carry.
    localparam int BYTE_MAX = MAX_DATA_BYTES + 3;
    localparam int BCW      = $clog2(BYTE_MAX + 1);
    localparam int ECW      = $clog2(MAX_DATA_BYTES + 1);

    rx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic        byte_ovf_q, byte_ovf_d;
    logic [ECW-1:0] emit_cnt_q, emit_cnt_d;
    logic [7:0]  hold0_q, hold0_d;
    logic [7:0]  hold1_q, hold1_d;
    logic        pid_ok_q, pid_ok_d;
    logic        err_q, err_d;

    logic        rx_pkt_start_q, rx_pkt_start_d;
    logic        rx_pkt_end_q, rx_pkt_end_d;
    logic        rx_pkt_valid_q, rx_pkt_valid_d;
    logic [3:0]  rx_pid_q, rx_pid_d;
    logic [6:0]  rx_addr_q, rx_addr_d;
    logic [3:0]  rx_endp_q, rx_endp_d;
    logic [10:0] rx_frame_num_q, rx_frame_num_d;
    logic        rx_data_put_q, rx_data_put_d;
    logic [7:0]  rx_data_q, rx_data_d;

    logic [7:0]  shift_next;
    logic [1:0]  ptype;
    logic        body_bit;
    logic        crc_clear;
    logic [4:0]  crc5;
    logic [15:0] crc16;
    logic        len_ok;
    logic        crc_ok;
    logic        pkt_ok;

    assign shift_next = {in_bit, shift_q[7:1]};
    assign ptype      = rx_pid_q[1:0];
    assign crc_clear  = reset | in_pkt_start;
    assign body_bit   = (state_q == ST_BODY) && in_bit_valid && !in_pkt_start && !in_pkt_end;

    usb_fs_crc #(
        .WIDTH (5),
        .POLY  (CRC5_POLY),
        .INIT  (CRC5_INIT)
    ) u_crc5 (
        .clk         (clk),
        .clear_i     (crc_clear),
        .bit_valid_i (body_bit),
        .bit_i       (in_bit),
        .crc_o       (crc5)
    );

    usb_fs_crc #(
        .WIDTH (16),
        .POLY  (CRC16_POLY),
        .INIT  (CRC16_INIT)
    ) u_crc16 (
        .clk         (clk),
        .clear_i     (crc_clear),
        .bit_valid_i (body_bit),
        .bit_i       (in_bit),
        .crc_o       (crc16)
    );

    // Packet judgement at EOP. byte_cnt_q saturates at BYTE_MAX; the
    // overflow flag catches packets longer than that.
    always_comb begin
        len_ok = 1'b0;
        crc_ok = 1'b0;
        case (ptype)
            PTYPE_TOKEN: begin
                len_ok = (byte_cnt_q == BCW'(3)) && !byte_ovf_q;
                crc_ok = (crc5 == CRC5_RESIDUAL);
            end
            PTYPE_HANDSHAKE: begin
                len_ok = (byte_cnt_q == BCW'(1)) && !byte_ovf_q;
                crc_ok = 1'b1;
            end
            PTYPE_DATA: begin
                len_ok = (byte_cnt_q >= BCW'(3)) && !byte_ovf_q;
                crc_ok = (crc16 == CRC16_RESIDUAL);
            end
            default: begin
                len_ok = 1'b0;
                crc_ok = 1'b0;
            end
        endcase
        pkt_ok = pid_ok_q && !err_q && !in_error && (bit_cnt_q == 3'd0) && len_ok && crc_ok;
    end

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        byte_ovf_d     = byte_ovf_q;
        emit_cnt_d     = emit_cnt_q;
        hold0_d        = hold0_q;
        hold1_d        = hold1_q;
        pid_ok_d       = pid_ok_q;
        err_d          = err_q;
        rx_pkt_start_d = 1'b0;
        rx_pkt_end_d   = 1'b0;
        rx_pkt_valid_d = 1'b0;
        rx_pid_d       = rx_pid_q;
        rx_addr_d      = rx_addr_q;
        rx_endp_d      = rx_endp_q;
        rx_frame_num_d = rx_frame_num_q;
        rx_data_put_d  = 1'b0;
        rx_data_d      = rx_data_q;

        if (in_pkt_start) begin
            // A new SYNC always wins; an unfinished packet is dropped silently.
            state_d        = ST_PID;
            shift_d        = '0;
            bit_cnt_d      = '0;
            byte_cnt_d     = '0;
            byte_ovf_d     = 1'b0;
            emit_cnt_d     = '0;
            hold0_d        = '0;
            hold1_d        = '0;
            pid_ok_d       = 1'b0;
            err_d          = 1'b0;
            rx_pkt_start_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_PID, ST_BODY: begin
                    if (in_error) begin
                        err_d = 1'b1;
                    end
                    if (in_pkt_end) begin
                        state_d        = ST_IDLE;
                        rx_pkt_end_d   = 1'b1;
                        rx_pkt_valid_d = pkt_ok;
                    end else if (in_bit_valid) begin
                        shift_d   = shift_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_cnt_q == BCW'(BYTE_MAX)) begin
                                byte_ovf_d = 1'b1;
                            end else begin
                                byte_cnt_d = byte_cnt_q + BCW'(1);
                            end
                            if (state_q == ST_PID) begin
                                rx_pid_d = shift_next[3:0];
                                pid_ok_d = pid_check_ok(shift_next);
                                state_d  = ST_BODY;
                            end else begin
                                // byte_cnt_q here is the 1-based index of the
                                // body byte just completed. Two most recent
                                // bytes stay held back as potential CRC16.
                                hold0_d = shift_next;
                                hold1_d = hold0_q;
                                if ((ptype == PTYPE_DATA) && (byte_cnt_q >= BCW'(3)) &&
                                    (emit_cnt_q != ECW'(MAX_DATA_BYTES))) begin
                                    rx_data_put_d = 1'b1;
                                    rx_data_d     = hold1_q;
                                    emit_cnt_d    = emit_cnt_q + ECW'(1);
                                end
                                if ((ptype == PTYPE_TOKEN) && (byte_cnt_q == BCW'(2))) begin
                                    if (rx_pid_q == PID_SOF) begin
                                        rx_frame_num_d = {shift_next[2:0], hold0_q};
                                    end else begin
                                        rx_addr_d = hold0_q[6:0];
                                        rx_endp_d = {shift_next[2:0], hold0_q[7]};
                                    end
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            byte_cnt_q     <= '0;
            byte_ovf_q     <= 1'b0;
            emit_cnt_q     <= '0;
            hold0_q        <= '0;
            hold1_q        <= '0;
            pid_ok_q       <= 1'b0;
            err_q          <= 1'b0;
            rx_pkt_start_q <= 1'b0;
            rx_pkt_end_q   <= 1'b0;
            rx_pkt_valid_q <= 1'b0;
            rx_pid_q       <= '0;
            rx_addr_q      <= '0;
            rx_endp_q      <= '0;
            rx_frame_num_q <= '0;
            rx_data_put_q  <= 1'b0;
            rx_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            byte_ovf_q     <= byte_ovf_d;
            emit_cnt_q     <= emit_cnt_d;
            hold0_q        <= hold0_d;
            hold1_q        <= hold1_d;
            pid_ok_q       <= pid_ok_d;
            err_q          <= err_d;
            rx_pkt_start_q <= rx_pkt_start_d;
            rx_pkt_end_q   <= rx_pkt_end_d;
            rx_pkt_valid_q <= rx_pkt_valid_d;
            rx_pid_q       <= rx_pid_d;
            rx_addr_q      <= rx_addr_d;
            rx_endp_q      <= rx_endp_d;
            rx_frame_num_q <= rx_frame_num_d;
            rx_data_put_q  <= rx_data_put_d;
            rx_data_q      <= rx_data_d;
        end
    end

    assign rx_pkt_start = rx_pkt_start_q;
    assign rx_pkt_end   = rx_pkt_end_q;
    assign rx_pkt_valid = rx_pkt_valid_q;
    assign rx_pid       = rx_pid_q;
    assign rx_addr      = rx_addr_q;
    assign rx_endp      = rx_endp_q;
    assign rx_frame_num = rx_frame_num_q;
    assign rx_data_put  = rx_data_put_q;
    assign rx_data      = rx_data_q;

endmodule
